// File: rtl/hs_stream_fifo.sv
// hs_stream_fifo: valid/ready stream buffer, DEPTH-entry first-word-fall-through
// FIFO with registered head, occupancy count, almost-full flag and flush.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   flush        synchronous clear of contents (wins over push/pop)
//   s_valid      upstream word available
//   s_ready      FIFO can accept a word (registered)
//   s_data       upstream payload
//   m_valid      head word available (registered)
//   m_ready      downstream accepts head word
//   m_data       head payload (registered)
//   count        occupancy, 0..DEPTH
//   almost_full  count >= AF_LEVEL (registered)
//   overflow_err sticky: s_valid withdrawn while stalled
module hs_stream_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic [PW-1:0] cnt_n;
    logic [PW-1:0] cnt_ap;

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic stall_q;

    assign push  = s_valid & s_ready;
    assign pop   = m_valid & m_ready;

    // MSB of each pointer is the wrap bit
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    // Pointer difference is always 0..DEPTH, so it cannot saturate
    assign count = wr_ptr - rd_ptr;

    always_comb begin
        wr_ptr_n = wr_ptr + PW'(push);
        rd_ptr_n = rd_ptr + PW'(pop);
        cnt_ap   = count - PW'(pop);
        cnt_n    = wr_ptr_n - rd_ptr_n;
    end

    // Storage has no reset; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            almost_full  <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            s_ready      <= 1'b1;
            m_valid      <= 1'b0;
            almost_full  <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            s_ready     <= (cnt_n != PW'(DEPTH));
            m_valid     <= (cnt_n != '0);
            almost_full <= (cnt_n >= PW'(AF_LEVEL));
            // Head is refreshed every edge while non-empty. If the FIFO
            // drains to nothing but a word arrives this edge, that word
            // is not in memory yet, so take it straight from s_data.
            if (cnt_n != '0) begin
                if (cnt_ap == '0) begin
                    m_data <= s_data;
                end else begin
                    m_data <= mem[rd_ptr_n[AW-1:0]];
                end
            end
        end
    end

    // A producer that withdraws a stalled word has broken the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            stall_q <= s_valid & ~s_ready;
            if (stall_q && !s_valid) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && full))
                else $error("hs_stream_fifo: push while full");
            assert (!(pop && empty))
                else $error("hs_stream_fifo: pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_hs_stream_fifo.sv
// tb_hs_stream_fifo: directed self-checking bench for hs_stream_fifo
// (DATA_W=8, DEPTH=16, AF_LEVEL=12).
module tb_hs_stream_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow_err;

    int n_pass  = 0;
    int n_total = 0;

    hs_stream_fifo #(
        .DATA_W(8),
        .DEPTH(16),
        .AF_LEVEL(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .count(count),
        .almost_full(almost_full),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #20;
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready);
        else n_pass++;
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid);
        else n_pass++;
        n_total++;
        if (m_data !== 8'h00) $display("FAIL rst_m_data got %h want 00", m_data);
        else n_pass++;
        n_total++;
        if (count !== 5'd0) $display("FAIL rst_count got %0d want 0", count);
        else n_pass++;
        n_total++;
        if (almost_full !== 1'b0) $display("FAIL rst_af got %b want 0", almost_full);
        else n_pass++;
        n_total++;
        if (overflow_err !== 1'b0) $display("FAIL rst_oe got %b want 0", overflow_err);
        else n_pass++;
        #20;
        rst = 1'b1;
        step();
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL rel_s_ready got %b want 1", s_ready);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [7:0] got[$];
        int maxc = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            if (m_valid && m_ready) got.push_back(m_data);
            step();
            if (i == 0) begin
                n_total++;
                if (m_valid !== 1'b1) $display("FAIL first_valid got %b want 1", m_valid);
                else n_pass++;
                n_total++;
                if (m_data !== 8'h00) $display("FAIL first_data got %h want 00", m_data);
                else n_pass++;
            end
            if (int'(count) > maxc) maxc = int'(count);
        end
        s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (m_valid && m_ready) got.push_back(m_data);
            step();
        end
        n_total++;
        if (maxc > 2) $display("FAIL stream_maxcount got %0d want <=2", maxc);
        else n_pass++;
        n_total++;
        if (got.size() != 16) $display("FAIL stream_len got %0d want 16", got.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            n_total++;
            if (got[i] !== 8'(i)) $display("FAIL stream_word%0d got %h want %h", i, got[i], 8'(i));
            else n_pass++;
        end
        n_total++;
        if (count !== 5'd0 || m_valid !== 1'b0)
            $display("FAIL stream_empty got count=%0d m_valid=%b want 0/0", count, m_valid);
        else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_fill();
        int acc = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hA0 + i);
            if (s_ready) acc++;
            step();
            if (count == 5'd11) begin
                n_total++;
                if (almost_full !== 1'b0) $display("FAIL af_at11 got %b want 0", almost_full);
                else n_pass++;
            end
            if (count == 5'd12) begin
                n_total++;
                if (almost_full !== 1'b1) $display("FAIL af_at12 got %b want 1", almost_full);
                else n_pass++;
            end
            if (i == 15) begin
                n_total++;
                if (s_ready !== 1'b0) $display("FAIL full_s_ready got %b want 0", s_ready);
                else n_pass++;
                n_total++;
                if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count);
                else n_pass++;
                n_total++;
                if (almost_full !== 1'b1) $display("FAIL full_af got %b want 1", almost_full);
                else n_pass++;
            end
        end
        n_total++;
        if (acc != 16) $display("FAIL fill_accepted got %0d want 16", acc);
        else n_pass++;
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0)
            $display("FAIL full_head got %b/%h want 1/a0", m_valid, m_data);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        logic [7:0] got[$];
        logic [7:0] want;
        s_valid = 1'b1;
        s_data  = 8'hC0;
        m_ready = 1'b1;
        step();
        n_total++;
        if (count !== 5'd15) $display("FAIL fullpop_count got %0d want 15", count);
        else n_pass++;
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL fullpop_s_ready got %b want 1", s_ready);
        else n_pass++;
        n_total++;
        if (m_data !== 8'hA1) $display("FAIL fullpop_head got %h want a1", m_data);
        else n_pass++;
        step();
        n_total++;
        if (count !== 5'd15) $display("FAIL pushpop_count got %0d want 15", count);
        else n_pass++;
        n_total++;
        if (m_data !== 8'hA2) $display("FAIL pushpop_head got %h want a2", m_data);
        else n_pass++;
        s_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_valid && m_ready) got.push_back(m_data);
            step();
        end
        n_total++;
        if (got.size() != 15) $display("FAIL drain_len got %0d want 15", got.size());
        else n_pass++;
        for (int j = 0; j < 15 && j < got.size(); j++) begin
            want = (j < 14) ? 8'(8'hA2 + j) : 8'hC0;
            n_total++;
            if (got[j] !== want) $display("FAIL drain_word%0d got %h want %h", j, got[j], want);
            else n_pass++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] want;
        int sent = 0;
        int recvd = 0;
        int cyc = 0;
        while (recvd < 120 && cyc < 3000) begin
            s_valid = (sent < 120);
            s_data  = 8'(sent * 3 + 1);
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_total++;
                if (m_data !== want) $display("FAIL wrap_word%0d got %h want %h", recvd, m_data, want);
                else n_pass++;
                recvd++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                sent++;
            end
            step();
            cyc++;
            n_total++;
            if (int'(count) != exp_q.size())
                $display("FAIL wrap_count got %0d want %0d", count, exp_q.size());
            else n_pass++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_total++;
        if (recvd != 120) $display("FAIL wrap_received got %0d want 120", recvd);
        else n_pass++;
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            step();
        end
        s_valid = 1'b0;
        n_total++;
        if (count !== 5'd7) $display("FAIL preflush_count got %0d want 7", count);
        else n_pass++;
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        m_ready = 1'b1;
        step();
        flush = 1'b0;
        n_total++;
        if (count !== 5'd0) $display("FAIL flush_count got %0d want 0", count);
        else n_pass++;
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL flush_m_valid got %b want 0", m_valid);
        else n_pass++;
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL flush_s_ready got %b want 1", s_ready);
        else n_pass++;
        s_valid = 1'b1;
        s_data  = 8'h55;
        m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'h55)
            $display("FAIL postflush_head got %b/%h want 1/55", m_valid, m_data);
        else n_pass++;
        n_total++;
        if (count !== 5'd1) $display("FAIL postflush_count got %0d want 1", count);
        else n_pass++;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_total++;
        if (count !== 5'd0 || m_valid !== 1'b0)
            $display("FAIL postflush_drain got %0d/%b want 0/0", count, m_valid);
        else n_pass++;
    endtask

    task automatic test_error_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h80 + i);
            step();
        end
        n_total++;
        if (s_ready !== 1'b0 || overflow_err !== 1'b0)
            $display("FAIL err_pre got s_ready=%b oe=%b want 0/0", s_ready, overflow_err);
        else n_pass++;
        step();
        s_valid = 1'b0;
        step();
        n_total++;
        if (overflow_err !== 1'b1) $display("FAIL err_set got %b want 1", overflow_err);
        else n_pass++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_total++;
        if (overflow_err !== 1'b1 || count !== 5'd0)
            $display("FAIL err_sticky got oe=%b count=%0d want 1/0", overflow_err, count);
        else n_pass++;
        s_valid = 1'b1;
        s_data  = 8'h99;
        for (int i = 0; i < 3; i++) step();
        n_total++;
        if (count !== 5'd3 || m_data !== 8'h99)
            $display("FAIL burst got count=%0d data=%h want 3/99", count, m_data);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00)
            $display("FAIL async_rst_hs got %b/%b/%h want 0/0/00", s_ready, m_valid, m_data);
        else n_pass++;
        n_total++;
        if (count !== 5'd0 || almost_full !== 1'b0 || overflow_err !== 1'b0)
            $display("FAIL async_rst_st got %0d/%b/%b want 0/0/0", count, almost_full, overflow_err);
        else n_pass++;
        #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        step();
        n_total++;
        if (s_ready !== 1'b1 || overflow_err !== 1'b0)
            $display("FAIL after_rst got %b/%b want 1/0", s_ready, overflow_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_pop();
        test_wrap();
        test_flush();
        test_error_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hs_stream_fifo.md
Name: hs_stream_fifo

Overview:
Parametrised valid/ready stream buffer. It is the next generation of the fixed 8-bit single-stage handshake path in `top`. It decouples an upstream producer from a downstream consumer through a DEPTH-entry first-word-fall-through FIFO. It also provides an occupancy count, an almost-full flag and a synchronous flush. It sits between any handshake source and sink in the design and is inserted wherever backpressure must be absorbed.

Parameters:
DATA_W, 8, payload width in bits (>=1)
DEPTH, 16, number of entries; power of two, 2..1024
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low; all state cleared while low
flush  input  1  synchronous clear of contents; takes priority over push/pop
s_valid  input  1  upstream word available
s_ready  output  1  FIFO can accept a word
s_data  input  DATA_W  upstream payload
m_valid  output  1  head word available to downstream
m_ready  input  1  downstream accepts head word
m_data  output  DATA_W  head payload
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow_err  output  1  sticky: s_valid held while s_valid dropped before s_ready (protocol violation)

Behaviour:
- Reset (rst low, async): wr_ptr=rd_ptr=0, count=0, s_ready=0, m_valid=0, m_data=0, almost_full=0, overflow_err=0. Memory contents are don't-care.
- First edge after rst deasserts: s_ready becomes 1. s_ready is registered and equals !(count==DEPTH) after each edge.
- push = s_valid & s_ready; pop = m_valid & m_ready. Both are evaluated on the same edge.
- Push writes s_data to mem[wr_ptr] and increments wr_ptr modulo DEPTH. Pop increments rd_ptr modulo DEPTH.
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit. Full: low bits equal, MSB differs. Empty: pointers equal.
- count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with m_ready=1: pop occurs and s_ready=0 for that cycle, so no push. s_ready rises on the next cycle. There is no same-cycle pass-through when full.
- Empty with s_valid=1: the word is written at edge N. m_valid=1 and m_data=word after edge N, giving 1-cycle latency. There is no combinational bypass.
- m_data is registered and holds the head word while m_valid & !m_ready, stable until pop.
- m_valid=0 when empty. m_data holds its last value in that case, and the sink must ignore it.
- Simultaneous push and pop at count=1: the head is popped and the new word becomes head on the next cycle. m_valid stays 1 and count stays 1.
- Ordering is strictly FIFO. No word may be dropped or duplicated across pointer wrap.
- almost_full is registered from next count.
- flush=1 at an edge sets pointers=0, count=0, m_valid=0 and s_ready=1 (s_ready stays 1 even if full). Push and pop in that cycle are discarded. overflow_err is not cleared by flush.
- overflow_err: set if, at an edge, s_valid was 1 with s_ready 0 in the previous cycle and s_valid is 0 now with no accept. Cleared only by rst.
- Reset mid-operation: all state clears immediately regardless of the clock. In-flight words are lost.
- Width rules: count saturation is impossible by construction. The implementation asserts in simulation if a push occurs when full or a pop occurs when empty.

Test Plan:
1. Reset then stream: release rst at 40 ns. Push 0x00..0x0F back-to-back with m_ready=1 -> m_data sequence 0x00..0x0F, first m_valid one cycle after first push, count never exceeds 2.
2. Fill to full: m_ready=0, push 20 words 0xA0.. -> 16 accepted, s_ready=0 after the 16th, count=16, almost_full=1 from count 12. Then m_ready=1 -> 0xA0..0xAF out in order.
3. Full with simultaneous pop: FIFO full, s_valid=1, m_ready=1 for one cycle -> one pop, no push, count=15, s_ready=1 the next cycle, next push accepted.
4. Wrap-around: 3 rounds of 40 words with random m_ready (50%) -> output equals input scoreboard exactly, with no loss or duplicate across pointer wrap.
5. Flush: count=7, assert flush for one cycle with s_valid=1 and m_ready=1 -> count=0, m_valid=0, next pushed word 0x55 appears as head after 1 cycle.
6. Async reset mid-burst and protocol error: drop s_valid while s_ready=0 -> overflow_err=1 and sticky through flush. Pulse rst low between clock edges -> all outputs are at reset values before the next edge.
